// File: rtl/bitstuff_stream.sv
// HDLC-style zero insertion: walks a DATA_W-bit word MSB first and emits a stuffed, MSB-aligned word.
// Optional feature macro: BITSTUFF_CARRY_EN (the ones run continues across consecutive words).
module bitstuff_stream #(
   parameter int DATA_W  = 40,
   parameter int RUN_LEN = 5,
   parameter int OUT_W   = DATA_W + (DATA_W + RUN_LEN - 1) / RUN_LEN,
   parameter int LEN_W   = $clog2(OUT_W + 1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] data_in,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [OUT_W-1:0]  out_data,
   output logic [LEN_W-1:0]  out_len,
   output logic [LEN_W-1:0]  stuff_cnt
);

   localparam int ONES_W = $clog2(RUN_LEN + 1);
   localparam int REM_W  = $clog2(DATA_W + 1);
   localparam logic [ONES_W-1:0] RUN_MAX  = ONES_W'(RUN_LEN);
   localparam logic [LEN_W-1:0]  TOP_POS  = LEN_W'(OUT_W - 1);
   localparam logic [REM_W-1:0]  ALL_BITS = REM_W'(DATA_W);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t              state_q;
   logic [DATA_W-1:0]   data_q;
   logic [REM_W-1:0]    rem_q;
   logic [ONES_W-1:0]   ones_q;
   logic [OUT_W-1:0]    out_data_q;
   logic [LEN_W-1:0]    out_len_q;
   logic [LEN_W-1:0]    stuff_cnt_q;
   logic                out_valid_q;

   logic                stuff_now;
   logic                cur_bit;
   logic [ONES_W-1:0]   ones_d;
   logic [LEN_W-1:0]    wr_pos;

   always_comb begin
      stuff_now = (ones_q == RUN_MAX);
      cur_bit   = data_q[DATA_W-1];
      ones_d    = cur_bit ? ones_q + 1'b1 : '0;
      wr_pos    = TOP_POS - out_len_q;
   end

   // NOTE: every register below uses non-blocking assignment so all updates in a cycle see the old values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         data_q      <= '0;
         rem_q       <= '0;
         ones_q      <= '0;
         out_data_q  <= '0;
         out_len_q   <= '0;
         stuff_cnt_q <= '0;
         out_valid_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (in_valid) begin
                  data_q      <= data_in;
                  rem_q       <= ALL_BITS;
                  out_data_q  <= '0;
                  out_len_q   <= '0;
                  stuff_cnt_q <= '0;
`ifdef BITSTUFF_CARRY_EN
                  ones_q      <= ones_q;
`else
                  ones_q      <= '0;
`endif
                  state_q     <= SHIFT;
               end
            end

            SHIFT: begin
               out_len_q <= out_len_q + 1'b1;
               if (stuff_now) begin
                  // Stuffed zero: out_data was cleared on accept, so only the counters move.
                  ones_q      <= '0;
                  stuff_cnt_q <= stuff_cnt_q + 1'b1;
                  if (rem_q == '0) begin
                     state_q     <= DONE;
                     out_valid_q <= 1'b1;
                  end
               end else begin
                  out_data_q[wr_pos] <= cur_bit;
                  ones_q             <= ones_d;
                  data_q             <= data_q << 1;
                  rem_q              <= rem_q - 1'b1;
                  if ((rem_q == REM_W'(1)) && (ones_d != RUN_MAX)) begin
                     state_q     <= DONE;
                     out_valid_q <= 1'b1;
                  end
               end
            end

            DONE: begin
               if (out_ready) begin
                  out_valid_q <= 1'b0;
                  state_q     <= IDLE;
               end
            end

            default: begin
               state_q     <= IDLE;
               out_valid_q <= 1'b0;
            end
         endcase
      end
   end

   // in_ready is gated by rst so it reads 0 during reset and 1 in the first cycle after release.
   assign in_ready  = (state_q == IDLE) && !rst;
   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_len   = out_len_q;
   assign stuff_cnt = stuff_cnt_q;

endmodule

// File: tb/tb_bitstuff_stream.sv
// Directed self-checking bench for bitstuff_stream with hand-computed stuffed words.
// Build with +define+BITSTUFF_CARRY_EN to cover the run-carry mode.
module tb_bitstuff_stream;

   localparam int DATA_W = 40;
   localparam int OUT_W  = 48;
   localparam int LEN_W  = 6;
   localparam int LAT_LIMIT = 200;

   logic              clk;
   logic              rst;
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] data_in;
   logic              out_valid;
   logic              out_ready;
   logic [OUT_W-1:0]  out_data;
   logic [LEN_W-1:0]  out_len;
   logic [LEN_W-1:0]  stuff_cnt;

   int n_checks = 0;
   int n_errors = 0;

   bitstuff_stream dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .data_in   (data_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_len   (out_len),
      .stuff_cnt (stuff_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Called at a negedge with the DUT idle; returns once out_valid is seen (or the bound expires).
   task automatic send_word(input logic [DATA_W-1:0] d, output int lat);
      check("ready_before_send", in_ready, 1);
      in_valid = 1'b1;
      data_in  = d;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      data_in  = '0;
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!out_valid && lat < LAT_LIMIT);
      check("out_valid_seen", out_valid, 1);
   endtask

   task automatic expect_word(input string tag, input logic [DATA_W-1:0] d,
                              input logic [OUT_W-1:0] exp_data, input int exp_len,
                              input int exp_stuff);
      int lat;
      send_word(d, lat);
      check({tag, "_data"},    out_data,  exp_data);
      check({tag, "_len"},     out_len,   exp_len);
      check({tag, "_stuff"},   stuff_cnt, exp_stuff);
      check({tag, "_latency"}, lat,       exp_len + 1);
   endtask

   task automatic release_word();
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check("release_valid_low", out_valid, 0);
      check("release_in_ready",  in_ready,  1);
   endtask

   initial begin
      #1ms;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "simulation time limit reached");
   end

   initial begin
      rst       = 1'b1;
      in_valid  = 1'b0;
      data_in   = '0;
      out_ready = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_in_ready",  in_ready,  0);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_data",  out_data,  0);
      check("rst_out_len",   out_len,   0);
      check("rst_stuff_cnt", stuff_cnt, 0);
      rst = 1'b0;
      #1;
      check("post_rst_in_ready", in_ready, 1);
      @(negedge clk);

      // All ones: 111110 repeated, including the trailing stuffed zero.
      expect_word("ones", 40'hFF_FFFF_FFFF, 48'hFBEF_BEFB_EFBE, 48, 8);
      release_word();

      expect_word("mixed", 40'hFA_4A52_A53F, 48'hF925_2952_9F40, 42, 2);
      release_word();

      expect_word("zeros", 40'h00_0000_0000, 48'h0000_0000_0000, 40, 0);
      release_word();

      expect_word("tail4", 40'h00_0000_000F, 48'h0000_0000_0F00, 40, 0);
      release_word();
`ifdef BITSTUFF_CARRY_EN
      // Carried run of 4 plus the first 1 reaches 5: 1, stuffed 0, 111, zeros.
      expect_word("head4", 40'hF0_0000_0000, 48'hB800_0000_0000, 41, 1);
`else
      expect_word("head4", 40'hF0_0000_0000, 48'hF000_0000_0000, 40, 0);
`endif
      release_word();

      // Backpressure: hold DONE for 10 cycles with a stray in_valid pulse.
      expect_word("bp", 40'hFA_4A52_A53F, 48'hF925_2952_9F40, 42, 2);
      for (int i = 0; i < 10; i++) begin
         if (i == 4) begin
            in_valid = 1'b1;
            data_in  = 40'hFF_FFFF_FFFF;
         end else begin
            in_valid = 1'b0;
            data_in  = '0;
         end
         @(negedge clk);
         check("bp_valid",    out_valid, 1);
         check("bp_in_ready", in_ready,  0);
         check("bp_data",     out_data,  48'hF925_2952_9F40);
         check("bp_len",      out_len,   42);
         check("bp_stuff",    stuff_cnt, 2);
      end
      in_valid = 1'b0;
      release_word();
      check("bp_nothing_latched", out_data, 48'hF925_2952_9F40);
      @(negedge clk);
      check("bp_still_idle", in_ready, 1);

      // Reset 20 cycles into SHIFT of the all-ones word.
      in_valid = 1'b1;
      data_in  = 40'hFF_FFFF_FFFF;
      @(negedge clk);
      in_valid = 1'b0;
      data_in  = '0;
      repeat (19) @(negedge clk);
      check("mid_shift_busy", in_ready, 0);
      rst = 1'b1;
      #1;
      check("midrst_in_ready",  in_ready,  0);
      check("midrst_out_valid", out_valid, 0);
      check("midrst_out_data",  out_data,  0);
      check("midrst_out_len",   out_len,   0);
      check("midrst_stuff_cnt", stuff_cnt, 0);
      repeat (2) @(negedge clk);
      check("midrst_hold_len", out_len, 0);
      rst = 1'b0;
      #1;
      check("midrst_release_ready", in_ready, 1);
      @(negedge clk);
      expect_word("after_rst", 40'h00_0000_0000, 48'h0000_0000_0000, 40, 0);
      release_word();

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
